// File: rtl/vdp1_fb_pkg.sv
// Shared constants, reader state encoding and line-base helper for VDP1 framebuffer scan-out.
package vdp1_fb_pkg;
    localparam int FB_WIDTH  = 352;
    localparam int FB_HEIGHT = 256;
    localparam int FB_ADDR_W = 17;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

    typedef enum logic [1:0] {IDLE, READ, ERASE, DRAIN} reader_state_e;

    // y*352 built from shifts because 352 = 256 + 64 + 32.
    function automatic logic [FB_ADDR_W-1:0] line_base(input logic [$clog2(FB_HEIGHT)-1:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = FB_ADDR_W'(y);
        return (yw << 8) + (yw << 6) + (yw << 5);
    endfunction
endpackage

// File: rtl/vdp1_fb_line_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on data_o whenever valid_o is high.
module vdp1_fb_line_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Data is forced to zero when empty so stale RAM contents never leak out.
    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;
endmodule

// File: rtl/vdp1_fb_line_reader.sv
// VDP1 framebuffer line scan-out: sequential reads into a pixel FIFO with optional erase-behind writes.
module vdp1_fb_line_reader
    import vdp1_fb_pkg::*;
#(
    parameter int ADDR_W     = $clog2(FB_WORDS),
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [7:0]        line_y,
    input  logic [8:0]        line_w,
    input  logic              erase_en,
    input  logic [15:0]       erase_val,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_data,
    output logic [1:0]        fb_wren,
    input  logic [15:0]       fb_q,
    output logic              pix_valid,
    output logic [15:0]       pix_data,
    input  logic              pix_ready,
    output logic              busy,
    output logic              line_done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, last_addr_q, last_addr_d, rd_addr;
    logic [8:0]        w_q, w_d, x_q, x_d, pop_cnt_q, pop_cnt_d, w_clamped;
    logic              erase_en_q, erase_en_d, inflight_q, inflight_d;
    logic [15:0]       erase_val_q, erase_val_d;
    logic [CW-1:0]     fifo_count;
    logic              credit_ok, pop_fire;

    vdp1_fb_line_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (inflight_q),
        .push_data_i (fb_q),
        .pop_i       (pix_ready),
        .valid_o     (pix_valid),
        .data_o      (pix_data),
        .count_o     (fifo_count)
    );

    // A read is only issued when its pixel is guaranteed a FIFO slot on arrival.
    assign credit_ok = (fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH);
    assign pop_fire  = pix_valid & pix_ready;
    assign rd_addr   = base_q + ADDR_W'(x_q);
    assign w_clamped = (line_w > 9'(FB_WIDTH)) ? 9'(FB_WIDTH) : line_w;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        w_d         = w_q;
        x_d         = x_q;
        erase_en_d  = erase_en_q;
        erase_val_d = erase_val_q;
        last_addr_d = last_addr_q;
        inflight_d  = 1'b0;
        pop_cnt_d   = pop_fire ? pop_cnt_q + 9'd1 : pop_cnt_q;
        fb_addr     = last_addr_q;
        fb_data     = '0;
        fb_wren     = 2'b00;
        line_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_start) begin
                    base_d      = ADDR_W'(line_base(line_y));
                    w_d         = w_clamped;
                    x_d         = '0;
                    pop_cnt_d   = '0;
                    erase_en_d  = erase_en;
                    erase_val_d = erase_val;
                    state_d     = (w_clamped == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (credit_ok) begin
                    fb_addr     = rd_addr;
                    last_addr_d = rd_addr;
                    inflight_d  = 1'b1;
                    x_d         = x_q + 9'd1;
                    if (erase_en_q) begin
                        state_d = ERASE;
                    end else if (x_q + 9'd1 == w_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            ERASE: begin
                fb_data = erase_val_q;
                fb_wren = 2'b11;
                state_d = (x_q == w_q) ? DRAIN : READ;
            end
            DRAIN: begin
                if ((w_q == '0) || (pop_fire && (pop_cnt_q == w_q - 9'd1))) begin
                    line_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            w_q         <= '0;
            x_q         <= '0;
            erase_en_q  <= 1'b0;
            erase_val_q <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            pop_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            w_q         <= w_d;
            x_q         <= x_d;
            erase_en_q  <= erase_en_d;
            erase_val_q <= erase_val_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= inflight_d;
            pop_cnt_q   <= pop_cnt_d;
        end
    end
endmodule
